// File: rtl/arb_pkg.sv
// Shared types and constants for the 8-way arbiter and its priority picker.
package arb_pkg;

    localparam int unsigned N    = 8;
    localparam int unsigned IdxW = 3;

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    // Index one below i, wrapping 0 -> N-1; used as the next scan start after a grant ends.
    function automatic logic [IdxW-1:0] prev_idx(input logic [IdxW-1:0] i);
        return i - 1'b1;
    endfunction

endpackage

// File: rtl/prio_pick_8.sv
// Combinational priority picker: scans req downward from ptr (wrapping) and
// returns the first set bit as a one-hot vector and as an index.
module prio_pick_8
    import arb_pkg::*;
(
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [N-1:0]    pick_o,
    output logic [IdxW-1:0] index_o,
    output logic            any_o
);

    logic            found;
    logic [IdxW-1:0] cand;

    always_comb begin
        found   = 1'b0;
        cand    = '0;
        index_o = '0;
        for (int unsigned j = 0; j < N; j++) begin
            cand = ptr_i - IdxW'(j);
            if (!found && req_i[cand]) begin
                found   = 1'b1;
                index_o = cand;
            end
        end
        any_o  = found;
        pick_o = found ? (N'(1) << index_o) : '0;
    end

endmodule

// File: rtl/arb_rr_8.sv
// 8-requester arbiter with round-robin or fixed priority, registered one-hot
// grant, and a MAX_HOLD timeout that revokes a grant held too long.
module arb_rr_8
    import arb_pkg::*;
#(
    parameter bit          RR       = 1'b1,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    grant,
    output logic            busy,
    output logic [IdxW-1:0] owner,
    output logic            expire
);

    localparam logic [7:0] HoldMax = 8'(MAX_HOLD);

    state_e          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [IdxW-1:0] owner_q, owner_d;
    logic            busy_q, busy_d;
    logic            expire_q, expire_d;
    logic [7:0]      hold_q, hold_d;
    logic [IdxW-1:0] ptr_q, ptr_d;

    logic [N-1:0]    pick;
    logic [IdxW-1:0] pick_idx;
    logic            pick_any;

    prio_pick_8 u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .pick_o  (pick),
        .index_o (pick_idx),
        .any_o   (pick_any)
    );

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        owner_d  = owner_q;
        busy_d   = busy_q;
        expire_d = 1'b0;
        hold_d   = hold_q;
        ptr_d    = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = GRANT;
                    grant_d = pick;
                    owner_d = pick_idx;
                    busy_d  = 1'b1;
                    // Counts cycles with grant high, so the first grant cycle is 1.
                    hold_d  = 8'd1;
                end
            end
            GRANT: begin
                if (!req[owner_q] || hold_q >= HoldMax) begin
                    // Release takes precedence: expire only when the owner still requests.
                    expire_d = req[owner_q];
                    state_d  = IDLE;
                    grant_d  = '0;
                    owner_d  = '0;
                    busy_d   = 1'b0;
                    hold_d   = '0;
                    ptr_d    = RR ? prev_idx(owner_q) : IdxW'(N - 1);
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            owner_q  <= '0;
            busy_q   <= 1'b0;
            expire_q <= 1'b0;
            hold_q   <= '0;
            ptr_q    <= IdxW'(N - 1);
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            busy_q   <= busy_d;
            expire_q <= expire_d;
            hold_q   <= hold_d;
            ptr_q    <= ptr_d;
        end
    end

    assign grant  = grant_q;
    assign owner  = owner_q;
    assign busy   = busy_q;
    assign expire = expire_q;

endmodule

// File: tb/tb_arb_rr_8.sv
// Bench for arb_rr_8: three configurations (RR, fixed, short hold) share stimulus
// and are checked against a behavioural model plus directed expectations.
module tb_arb_rr_8;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] req;

    logic [7:0] g [3];
    logic [2:0] o [3];
    logic       b [3];
    logic       e [3];

    always #5 clk = ~clk;

    arb_rr_8 #(.RR(1'b1), .MAX_HOLD(16)) u_rr (
        .clk(clk), .reset(reset), .req(req),
        .grant(g[0]), .busy(b[0]), .owner(o[0]), .expire(e[0])
    );
    arb_rr_8 #(.RR(1'b0), .MAX_HOLD(16)) u_fixed (
        .clk(clk), .reset(reset), .req(req),
        .grant(g[1]), .busy(b[1]), .owner(o[1]), .expire(e[1])
    );
    arb_rr_8 #(.RR(1'b1), .MAX_HOLD(4)) u_short (
        .clk(clk), .reset(reset), .req(req),
        .grant(g[2]), .busy(b[2]), .owner(o[2]), .expire(e[2])
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state per configuration.
    int cfg_hold [3] = '{16, 16, 4};
    bit cfg_rr   [3] = '{1'b1, 1'b0, 1'b1};
    bit m_busy   [3];
    int m_owner  [3];
    int m_hold   [3];
    int m_ptr    [3];
    bit m_exp    [3];

    function automatic void model_end(int k, bit timed_out);
        m_exp[k]   = timed_out;
        m_busy[k]  = 1'b0;
        m_ptr[k]   = cfg_rr[k] ? (m_owner[k] + 7) % 8 : 7;
        m_owner[k] = 0;
        m_hold[k]  = 0;
    endfunction

    function automatic void model_step(int k, bit rst, logic [7:0] r);
        if (rst) begin
            m_busy[k] = 1'b0; m_owner[k] = 0; m_hold[k] = 0; m_ptr[k] = 7; m_exp[k] = 1'b0;
        end else begin
            m_exp[k] = 1'b0;
            if (!m_busy[k]) begin
                for (int j = 0; j < 8; j++) begin
                    int c;
                    c = (m_ptr[k] - j + 8) % 8;
                    if (!m_busy[k] && r[c]) begin
                        m_busy[k] = 1'b1; m_owner[k] = c; m_hold[k] = 1;
                    end
                end
            end else if (!r[m_owner[k]]) begin
                model_end(k, 1'b0);
            end else if (m_hold[k] >= cfg_hold[k]) begin
                model_end(k, 1'b1);
            end else begin
                m_hold[k]++;
            end
        end
    endfunction

    task automatic cmp(string name, int k, logic [7:0] eg, logic [2:0] eo, logic eb, logic ee);
        n_tests++;
        if ({g[k], o[k], b[k], e[k]} !== {eg, eo, eb, ee}) begin
            n_fail++;
            $display("FAIL %s dut%0d: got grant=%b owner=%0d busy=%b expire=%b, want grant=%b owner=%0d busy=%b expire=%b",
                     name, k, g[k], o[k], b[k], e[k], eg, eo, eb, ee);
        end
    endtask

    // Drive one cycle of inputs at negedge, advance, then compare all DUTs to the model.
    task automatic cycle(bit rst, logic [7:0] r);
        reset = rst;
        req   = r;
        for (int k = 0; k < 3; k++) model_step(k, rst, r);
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            logic [7:0] mg;
            mg = m_busy[k] ? (8'b1 << m_owner[k]) : 8'b0;
            cmp("model", k, mg, 3'(m_owner[k]), m_busy[k], m_exp[k]);
        end
    endtask

    typedef struct {
        bit         rst;
        logic [7:0] req;
        logic [7:0] grant;
        logic [2:0] owner;
        logic       busy;
        logic       expire;
    } vec_t;

    vec_t tbl [15];

    initial begin
        logic [7:0] r;
        bit         rst;

        // Directed vectors for the round-robin configuration (dut0).
        tbl[0]  = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 8'h81, 8'h80, 3'd7, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 8'h81, 8'h80, 3'd7, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 8'h81, 8'h80, 3'd7, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 8'h01, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 8'h01, 8'h01, 3'd0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 8'h81, 8'h01, 3'd0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 8'h80, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 8'h81, 8'h80, 3'd7, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 8'hFF, 8'h80, 3'd7, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 8'h7F, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 8'hFF, 8'h40, 3'd6, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};

        reset = 1'b1;
        req   = 8'h00;
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            cycle(tbl[i].rst, tbl[i].req);
            cmp($sformatf("vec%0d", i), 0, tbl[i].grant, tbl[i].owner, tbl[i].busy, tbl[i].expire);
        end

        // Fixed priority: requester 7 reasserting during the bubble wins again.
        cycle(1'b1, 8'h00);
        cycle(1'b0, 8'h81);
        cmp("fixed_first", 1, 8'h80, 3'd7, 1'b1, 1'b0);
        cycle(1'b0, 8'h81);
        cycle(1'b0, 8'h81);
        cycle(1'b0, 8'h01);
        cmp("fixed_bubble", 1, 8'h00, 3'd0, 1'b0, 1'b0);
        cycle(1'b0, 8'h81);
        cmp("fixed_regrant", 1, 8'h80, 3'd7, 1'b1, 1'b0);
        cmp("rr_rotates", 0, 8'h01, 3'd0, 1'b1, 1'b0);

        // Timeout with MAX_HOLD=4: four grant cycles, one expire cycle, then regrant.
        cycle(1'b1, 8'h00);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 8'h04);
            cmp($sformatf("hold%0d", i), 2, 8'h04, 3'd2, 1'b1, 1'b0);
        end
        cycle(1'b0, 8'h04);
        cmp("timeout_expire", 2, 8'h00, 3'd0, 1'b0, 1'b1);
        cmp("no_timeout_long", 0, 8'h04, 3'd2, 1'b1, 1'b0);
        cycle(1'b0, 8'h04);
        cmp("timeout_regrant", 2, 8'h04, 3'd2, 1'b1, 1'b0);

        // Release in the same cycle the hold limit is reached: no expire.
        cycle(1'b1, 8'h00);
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h04);
        cycle(1'b0, 8'h00);
        cmp("release_beats_timeout", 2, 8'h00, 3'd0, 1'b0, 1'b0);

        // Random traffic, mostly held requests so long grants and timeouts occur.
        r = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            case ($urandom_range(0, 7))
                0:       r = 8'($urandom);
                1:       r = 8'($urandom) & 8'($urandom);
                2:       r = 8'h00;
                3:       r = r & 8'($urandom);
                default: r = r;
            endcase
            cycle(rst, r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
